// File: rtl/hotkey_pkg.sv
// rtl/hotkey_pkg.sv - shared types and defaults for the hotkey combo controller
package hotkey_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_HOLD         = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } hk_state_e;

  localparam int          HK_BTN_W    = 16;
  localparam int          HK_N_COMBOS = 4;
  // 2 s at 28.375160 MHz
  localparam int unsigned HOLD_2S_28M = 32'd56750320;

  // Width of an index into N combos; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/combo_priority_match.sv
// rtl/combo_priority_match.sv - per-combo mask match and lowest-index winner
module combo_priority_match
  import hotkey_pkg::*;
#(
  parameter int N_COMBOS = HK_N_COMBOS,
  parameter int BTN_W    = HK_BTN_W,
  localparam int OW      = owner_w(N_COMBOS)
) (
  input  logic [BTN_W-1:0]          buttons,
  input  logic [N_COMBOS*BTN_W-1:0] combo_mask,
  output logic [N_COMBOS-1:0]       match,
  output logic [OW-1:0]             winner,
  output logic                      any_match
);

  // A combo matches when its mask is non-empty and every masked button is down;
  // extra pressed buttons do not prevent a match.
  always_comb begin
    logic [BTN_W-1:0] m;
    m     = '0;
    match = '0;
    for (int i = 0; i < N_COMBOS; i++) begin
      m        = combo_mask[i*BTN_W +: BTN_W];
      match[i] = (|m) && ((buttons & m) == m);
    end
  end

  // Lowest index wins: scan from the top so lower indices overwrite.
  always_comb begin
    winner = '0;
    for (int i = N_COMBOS - 1; i >= 0; i--) begin
      if (match[i]) winner = OW'(i);
    end
  end

  assign any_match = |match;

endmodule

// File: rtl/hotkey_combo_controller.sv
// rtl/hotkey_combo_controller.sv - shared hold timer arbitrated among button combos
module hotkey_combo_controller
  import hotkey_pkg::*;
#(
  parameter int          N_COMBOS    = HK_N_COMBOS,
  parameter int          BTN_W       = HK_BTN_W,
  parameter int unsigned HOLD_CYCLES = HOLD_2S_28M,
  localparam int         OW          = owner_w(N_COMBOS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [BTN_W-1:0]          buttons,
  input  logic [N_COMBOS*BTN_W-1:0] combo_mask,
  output logic [N_COMBOS-1:0]       fire_pulse,
  output logic [N_COMBOS-1:0]       toggle_state,
  output logic [OW-1:0]             owner,
  output logic                      holding
);

  // Terminal count; comparing against it keeps the counter from ever wrapping.
  localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 32'd1;

  hk_state_e             state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [N_COMBOS-1:0]   fire_q, fire_d;
  logic [N_COMBOS-1:0]   tog_q, tog_d;

  logic [N_COMBOS-1:0]   match;
  logic [OW-1:0]         winner;
  logic                  any_match;
  logic [BTN_W-1:0]      owner_mask;

  combo_priority_match #(
    .N_COMBOS (N_COMBOS),
    .BTN_W    (BTN_W)
  ) u_match (
    .buttons    (buttons),
    .combo_mask (combo_mask),
    .match      (match),
    .winner     (winner),
    .any_match  (any_match)
  );

  assign owner_mask = combo_mask[32'(owner_q)*BTN_W +: BTN_W];

  // Next-state logic: disable overrides everything, release beats preemption.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    fire_d  = '0;
    tog_d   = tog_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_match) begin
            owner_d = winner;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!match[owner_q]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (winner < owner_q) begin
            owner_d = winner;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_LAST) begin
            fire_d[owner_q] = 1'b1;
            tog_d[owner_q]  = ~tog_q[owner_q];
            cnt_d           = '0;
            state_d         = ST_WAIT_RELEASE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_WAIT_RELEASE: begin
          // Wait for every button of the fired combo to lift; no auto-repeat.
          if ((buttons & owner_mask) == '0) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, timer and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      fire_q  <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      fire_q  <= fire_d;
      tog_q   <= tog_d;
    end
  end

  assign fire_pulse   = fire_q;
  assign toggle_state = tog_q;
  assign owner        = owner_q;
  assign holding      = (state_q == ST_HOLD);

endmodule

// File: tb/tb_hotkey_combo_controller.sv
// tb/tb_hotkey_combo_controller.sv - directed vector bench for hotkey_combo_controller
module tb_hotkey_combo_controller;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int HOLD = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           enable;
  logic [W-1:0]   buttons;
  logic [N*W-1:0] combo_mask;
  logic [N-1:0]   fire_pulse;
  logic [N-1:0]   toggle_state;
  logic [1:0]     owner;
  logic           holding;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [W-1:0] btn;
    logic [N-1:0] fire;
    logic [N-1:0] tog;
    logic         hold;
    string        name;
  } vec_t;

  vec_t vecs[$];

  hotkey_combo_controller #(
    .N_COMBOS    (N),
    .BTN_W       (W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .buttons      (buttons),
    .combo_mask   (combo_mask),
    .fire_pulse   (fire_pulse),
    .toggle_state (toggle_state),
    .owner        (owner),
    .holding      (holding)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic [W-1:0] b, input logic [N-1:0] f,
                     input logic [N-1:0] t, input logic h, input string nm);
    vec_t v;
    v.btn = b; v.fire = f; v.tog = t; v.hold = h; v.name = nm;
    vecs.push_back(v);
  endtask

  // Holds the current buttons for HOLD edges expecting no pulse, then one
  // more edge expecting the pulse for combo idx.
  task automatic hold_fire(input string nm, input int idx, input logic [N-1:0] tog_after);
    logic [N-1:0] exp_fire;
    exp_fire = '0;
    exp_fire[idx] = 1'b1;
    for (int e = 0; e < HOLD; e++) begin
      step();
      chk({nm, " hold"}, 32'(holding), 32'd1);
      chk({nm, " nofire"}, 32'(fire_pulse), 32'd0);
      chk({nm, " owner"}, 32'(owner), 32'(idx));
    end
    step();
    chk({nm, " fire"}, 32'(fire_pulse), 32'(exp_fire));
    chk({nm, " toggle"}, 32'(toggle_state), 32'(tog_after));
    chk({nm, " leave hold"}, 32'(holding), 32'd0);
  endtask

  initial begin
    int pulses;
    reset_n    = 1'b0;
    enable     = 1'b1;
    buttons    = '0;
    combo_mask = {16'h0000, 16'h0000, 16'h0000, 16'h0300};

    step();
    chk("reset fire", 32'(fire_pulse), 32'd0);
    chk("reset toggle", 32'(toggle_state), 32'd0);
    chk("reset owner", 32'(owner), 32'd0);
    chk("reset holding", 32'(holding), 32'd0);
    reset_n = 1'b1;
    step();

    // basic hold/fire, then early release and full re-hold
    for (int i = 0; i < HOLD; i++) add(16'h0300, 4'b0000, 4'b0000, 1'b1, "s1 hold");
    add(16'h0300, 4'b0001, 4'b0001, 1'b0, "s1 fire");
    add(16'h0300, 4'b0000, 4'b0001, 1'b0, "s1 wait");
    add(16'h0000, 4'b0000, 4'b0001, 1'b0, "s1 release");
    add(16'h0000, 4'b0000, 4'b0001, 1'b0, "s1 idle");
    for (int i = 0; i < 6; i++) add(16'h0300, 4'b0000, 4'b0001, 1'b1, "s2 hold");
    add(16'h0100, 4'b0000, 4'b0001, 1'b0, "s2 drop");
    for (int i = 0; i < HOLD; i++) add(16'h0300, 4'b0000, 4'b0001, 1'b1, "s2 rehold");
    add(16'h0300, 4'b0001, 4'b0000, 1'b0, "s2 fire");
    add(16'h0000, 4'b0000, 4'b0000, 1'b0, "s2 release");

    foreach (vecs[k]) begin
      buttons = vecs[k].btn;
      step();
      chk({vecs[k].name, " fire"}, 32'(fire_pulse), 32'(vecs[k].fire));
      chk({vecs[k].name, " toggle"}, 32'(toggle_state), 32'(vecs[k].tog));
      chk({vecs[k].name, " holding"}, 32'(holding), 32'(vecs[k].hold));
      chk({vecs[k].name, " owner"}, 32'(owner), 32'd0);
    end

    // no auto-repeat while held after fire
    buttons = 16'h0300;
    hold_fire("norepeat first", 0, 4'b0001);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fire_pulse != '0 || holding) pulses++;
    end
    chk("norepeat pulses", 32'(pulses), 32'd0);
    buttons = 16'h0000;
    step();
    chk("norepeat release", 32'(holding), 32'd0);
    buttons = 16'h0300;
    hold_fire("norepeat second", 0, 4'b0000);
    buttons = 16'h0000;
    step();

    // higher-priority superset preempts the owner and restarts the timer
    combo_mask = {16'h0000, 16'h0000, 16'h0300, 16'h0301};
    buttons = 16'h0300;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("preempt owner1", 32'(owner), 32'd1);
      chk("preempt hold1", 32'(holding), 32'd1);
      chk("preempt nofire1", 32'(fire_pulse), 32'd0);
    end
    buttons = 16'h0301;
    hold_fire("preempt", 0, 4'b0001);
    buttons = 16'h0000;
    step();
    chk("preempt released", 32'(holding), 32'd0);

    // asynchronous reset mid-hold, then a full hold from zero
    combo_mask = {16'h0000, 16'h0000, 16'h0000, 16'h0300};
    buttons = 16'h0300;
    for (int i = 0; i < 6; i++) step();
    chk("prereset hold", 32'(holding), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async fire", 32'(fire_pulse), 32'd0);
    chk("async toggle", 32'(toggle_state), 32'd0);
    chk("async owner", 32'(owner), 32'd0);
    chk("async holding", 32'(holding), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hold_fire("postreset", 0, 4'b0001);
    buttons = 16'h0000;
    step();

    // enable low aborts the hold without firing; re-enable needs a full hold
    buttons = 16'h0300;
    for (int i = 0; i < 4; i++) step();
    enable = 1'b0;
    step();
    chk("disable holding", 32'(holding), 32'd0);
    chk("disable fire", 32'(fire_pulse), 32'd0);
    chk("disable toggle", 32'(toggle_state), 32'd1);
    step();
    chk("disable stays idle", 32'(holding), 32'd0);
    enable = 1'b1;
    hold_fire("reenable", 0, 4'b0000);
    buttons = 16'h0000;
    step();

    // all-zero masks never match, even with every button pressed
    combo_mask = '0;
    buttons = 16'hFFFF;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fire_pulse != '0 || holding) pulses++;
    end
    chk("zero mask activity", 32'(pulses), 32'd0);
    chk("zero mask toggle", 32'(toggle_state), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
